regfile_exec_seq: RTL and testbench

REGFILE_EXEC_SEQ -- requirements
Module: regfile_exec_seq

---
 rtl/regfile_exec_seq.sv | 150 +++++++++++++++
 tb/tb_regfile_exec_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_exec_seq.sv
// regfile_exec_seq: sequences one register-file ALU operation.
// The sequence is read rn into A, read rm into B, compute C and the flags,
// then optionally write C back to rd. The register file sits outside and
// is read combinationally through readnum/rf_rdata.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               request, sampled only while idle
//   rn, rm, rd          operand and destination register numbers
//   op, shift, wb       ALU op, operand-B shift, write-back enable
//   rf_rdata            register-file read data
//   readnum, writenum   register-file read and write addresses
//   write, rf_wdata     register-file write enable and data
//   result, status      C register and its {N, V, Z} flags
//   busy, done          not-idle indicator; one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start; done pulses here for one cycle after WRITE
// READ_A | readnum = rn; A loads rf_rdata at the end of the cycle
// READ_B | readnum = rm; B loads rf_rdata at the end of the cycle
// EXEC   | C and status load from the ALU at the end of the cycle
// WRITE  | write asserted if wb; the register file updates at the end
module regfile_exec_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [2:0]       rd,
  input  logic [1:0]       op,
  input  logic [1:0]       shift,
  input  logic             wb,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, READ_A, READ_B, EXEC, WRITE} state_t;

  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [2:0]       rn_q, rm_q, rd_q;
  logic [1:0]       op_q, shift_q;
  logic             wb_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       status_q;
  logic             done_q;

  logic [WIDTH-1:0] bs;
  logic [WIDTH-1:0] c_next;
  logic             v_next;

  always_comb begin
    case (shift_q)
      2'b01:   bs = {b_q[MSB-1:0], 1'b0};
      2'b10:   bs = {1'b0, b_q[MSB:1]};
      2'b11:   bs = {b_q[MSB], b_q[MSB:1]};
      default: bs = b_q;
    endcase
  end

  // Overflow: ADD overflows when operands share a sign the sum does not;
  // SUB when operands differ in sign and the difference flips from A's sign.
  always_comb begin
    c_next = '0;
    v_next = 1'b0;
    case (op_q)
      2'b00: begin
        c_next = a_q + bs;
        v_next = (a_q[MSB] == bs[MSB]) && (c_next[MSB] != a_q[MSB]);
      end
      2'b01: begin
        c_next = a_q - bs;
        v_next = (a_q[MSB] != bs[MSB]) && (c_next[MSB] != a_q[MSB]);
      end
      2'b10:   c_next = a_q & bs;
      default: c_next = ~bs;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      op_q     <= '0;
      shift_q  <= '0;
      wb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            op_q    <= op;
            shift_q <= shift;
            wb_q    <= wb;
            state   <= READ_A;
          end
        end
        READ_A: begin
          a_q   <= rf_rdata;
          state <= READ_B;
        end
        READ_B: begin
          b_q   <= rf_rdata;
          state <= EXEC;
        end
        EXEC: begin
          c_q      <= c_next;
          status_q <= {c_next[MSB], v_next, (c_next == '0)};
          state    <= WRITE;
        end
        WRITE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign readnum  = (state == READ_B) ? rm_q : rn_q;
  assign writenum = rd_q;
  // Reset gates write directly so an abandoned WRITE never reaches the file.
  assign write    = (state == WRITE) && wb_q && !reset;
  assign rf_wdata = c_q;
  assign result   = c_q;
  assign status   = status_q;
  assign busy     = (state != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_regfile_exec_seq.sv
module tb_regfile_exec_seq;

  localparam int W = 16;
  localparam int MODW = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   rn, rm, rd;
  logic [1:0]   op, shift;
  logic         wb;
  logic [W-1:0] rf_rdata;
  logic [2:0]   readnum, writenum;
  logic         write;
  logic [W-1:0] rf_wdata, result;
  logic [2:0]   status;
  logic         busy, done;

  regfile_exec_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rn(rn), .rm(rm), .rd(rd), .op(op), .shift(shift), .wb(wb),
    .rf_rdata(rf_rdata), .readnum(readnum), .writenum(writenum),
    .write(write), .rf_wdata(rf_wdata), .result(result),
    .status(status), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment register file, with a backdoor used only while idle.
  logic [W-1:0] rf [8];
  logic         bd_en = 1'b0;
  logic [2:0]   bd_addr = '0;
  logic [W-1:0] bd_data = '0;
  assign rf_rdata = rf[readnum];
  always @(posedge clk) begin
    if (write) rf[writenum] <= rf_wdata;
    else if (bd_en) rf[bd_addr] <= bd_data;
  end

  // Reference state: register contents as the operation sequence implies.
  int mrf [8];

  typedef struct {
    int         e;
    logic [2:0] rn, rm, rd;
    logic       wb;
    logic [W-1:0] c;
    logic [2:0] st;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int to_signed(int v);
    return (v >= HALF) ? v - MODW : v;
  endfunction

  function automatic exp_t model_op(int e, logic [2:0] a_r, logic [2:0] b_r,
                                    logic [2:0] d_r, logic [1:0] o, logic [1:0] s, logic w);
    exp_t x;
    int a, b, bs, c, sum;
    bit v;
    a = mrf[a_r];
    b = mrf[b_r];
    case (s)
      2'd1:    bs = (b * 2) % MODW;
      2'd2:    bs = b / 2;
      2'd3:    bs = b / 2 + ((b >= HALF) ? HALF : 0);
      default: bs = b;
    endcase
    v = 1'b0;
    case (o)
      2'd0: begin
        c = (a + bs) % MODW;
        sum = to_signed(a) + to_signed(bs);
        v = (sum >= HALF) || (sum < -HALF);
      end
      2'd1: begin
        c = (a - bs + MODW) % MODW;
        sum = to_signed(a) - to_signed(bs);
        v = (sum >= HALF) || (sum < -HALF);
      end
      2'd2:    c = a & bs;
      default: c = MODW - 1 - bs;
    endcase
    x.e = e; x.rn = a_r; x.rm = b_r; x.rd = d_r; x.wb = w;
    x.c = c[W-1:0];
    x.st = {c >= HALF, v, c == 0};
    if (w) mrf[d_r] = c;
    return x;
  endfunction

  // Monitor: compares DUT activity against the scoreboard queue.
  bit seen_write = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && busy) begin
        if (cyc == q[0].e)     chk("readnum_a", readnum, q[0].rn);
        if (cyc == q[0].e + 1) chk("readnum_b", readnum, q[0].rm);
      end
      if (write) begin
        if (q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("write_cycle", cyc, q[0].e + 3);
          chk("write_wb", 1, q[0].wb);
          chk("writenum", writenum, q[0].rd);
          chk("rf_wdata", rf_wdata, q[0].c);
          seen_write = 1'b1;
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("done_cycle", cyc, q[0].e + 4);
          chk("done_busy", busy, 0);
          chk("result", result, q[0].c);
          chk("status", status, q[0].st);
          chk("write_seen", seen_write, q[0].wb);
          void'(q.pop_front());
          seen_write = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) return;
      step();
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic set_reg(logic [2:0] a, logic [W-1:0] v);
    bd_en = 1'b1; bd_addr = a; bd_data = v;
    mrf[a] = v;
    step();
    bd_en = 1'b0;
  endtask

  task automatic issue(logic [2:0] a_r, logic [2:0] b_r, logic [2:0] d_r,
                       logic [1:0] o, logic [1:0] s, logic w, bit push);
    wait_idle();
    rn = a_r; rm = b_r; rd = d_r; op = o; shift = s; wb = w;
    start = 1'b1;
    if (push) q.push_back(model_op(cyc + 1, a_r, b_r, d_r, o, s, w));
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int e0;
    reset = 1'b1; start = 1'b0;
    rn = '0; rm = '0; rd = '0; op = '0; shift = '0; wb = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_write", write, 0);
    chk("rst_result", result, 0);
    chk("rst_status", status, 0);
    start = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) set_reg(i[2:0], W'($urandom));

    // ADD
    set_reg(3'd1, 16'h0005); set_reg(3'd2, 16'h0003);
    issue(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b1, 1'b1);
    wait_idle();
    chk("add_result", result, 16'h0008);
    chk("add_status", status, 3'b000);
    // SUB compare, no write-back
    set_reg(3'd1, 16'h1234); set_reg(3'd2, 16'h1234);
    issue(3'd1, 3'd2, 3'd5, 2'b01, 2'b00, 1'b0, 1'b1);
    wait_idle();
    chk("sub_result", result, 16'h0000);
    chk("sub_status", status, 3'b001);
    // Signed overflow
    set_reg(3'd1, 16'h7FFF); set_reg(3'd2, 16'h0001);
    issue(3'd1, 3'd2, 3'd6, 2'b00, 2'b00, 1'b1, 1'b1);
    wait_idle();
    chk("ovf_result", result, 16'h8000);
    chk("ovf_status", status, 3'b110);
    // ASR then NOT
    set_reg(3'd2, 16'h8001);
    issue(3'd1, 3'd2, 3'd7, 2'b11, 2'b11, 1'b1, 1'b1);
    wait_idle();
    chk("not_result", result, 16'h3FFF);
    // Same register as both sources and destination
    set_reg(3'd4, 16'h0010);
    issue(3'd4, 3'd4, 3'd4, 2'b00, 2'b01, 1'b1, 1'b1);
    wait_idle();
    step();
    chk("same_reg_r4", rf[4], 16'h0030);

    // start pulses while busy must be ignored
    set_reg(3'd1, 16'h0100); set_reg(3'd2, 16'h0023);
    issue(3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rn = W'($urandom) % 8; rm = 3'd0; rd = 3'd0; op = 2'b11; wb = 1'b1;
      start = 1'b1;
      step();
    end
    start = 1'b0;
    wait_idle();
    chk("ignore_result", result, 16'h0123);

    // start held high: accepts every 5 cycles
    wait_idle();
    rn = 3'd3; rm = 3'd1; rd = 3'd3; op = 2'b00; shift = 2'b00; wb = 1'b1;
    start = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++)
      q.push_back(model_op(e0 + 5 * k, 3'd3, 3'd1, 3'd3, 2'b00, 2'b00, 1'b1));
    for (int i = 0; i < 30 && cyc < e0 + 10; i++) step();
    start = 1'b0;
    drain();
    chk("b2b_r3", rf[3], 16'h0423);

    // Reset during WRITE abandons the operation
    issue(3'd1, 3'd2, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0);
    repeat (3) step();
    chk("rw_busy_in_write", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_write_forced", write, 0);
    step();
    reset = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_done", done, 0);
    chk("rw_result", result, 0);
    chk("rw_status", status, 0);
    chk("rw_readnum", readnum, 0);
    step();
    chk("rw_done_after", done, 0);
    chk("rw_r0_kept", rf[0], mrf[0]);

    // Randomized operations with random idle gaps
    for (int n = 0; n < 40; n++) begin
      issue(3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
            2'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 6)) step();
    end
    drain();
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], mrf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
